// File: rtl/apb_led_pwm.sv
// APB3 multi-channel LED controller: per-channel off/PWM/blink/on modes, a shared
// prescaler and blink timer, and duty values double-buffered once per PWM period.
module apb_led_pwm #(
   parameter int NUM_LEDS      = 8,
   parameter int PWM_BITS      = 8,
   parameter int PRESCALE_BITS = 16
) (
   input  logic                PCLK,
   input  logic                PRESERN,
   input  logic                PSEL,
   input  logic                PENABLE,
   input  logic                PWRITE,
   input  logic [31:0]         PADDR,
   input  logic [31:0]         PWDATA,
   output logic [31:0]         PRDATA,
   output logic                PREADY,
   output logic                PSLVERR,
   output logic [NUM_LEDS-1:0] LED
);

   localparam logic [5:0] IDX_CTRL     = 6'd0;
   localparam logic [5:0] IDX_PRESCALE = 6'd1;
   localparam logic [5:0] IDX_MODE     = 6'd2;
   localparam logic [5:0] IDX_BLINK    = 6'd3;
   localparam logic [5:0] IDX_STATUS   = 6'd4;
   localparam logic [5:0] IDX_DUTY0    = 6'd8;

   logic [1:0]               ctrl_q;
   logic [PRESCALE_BITS-1:0] prescale_q;
   logic [2*NUM_LEDS-1:0]    mode_q;
   logic [15:0]              blink_q;
   logic [PWM_BITS-1:0]      duty_q   [NUM_LEDS];
   logic [PWM_BITS-1:0]      shadow_q [NUM_LEDS];

   logic [PRESCALE_BITS-1:0] presc_cnt_q, presc_cnt_d;
   logic [PWM_BITS-1:0]      pwm_cnt_q, pwm_cnt_d;
   logic [15:0]              blink_cnt_q, blink_cnt_d;
   logic                     phase_q, phase_d;
   logic [NUM_LEDS-1:0]      led_q, led_d;

   logic [5:0]               idx_s;
   logic                     is_duty_s;
   logic                     mapped_s;
   logic                     wr_ok_s;
   logic                     wr_prescale_s;
   logic                     en_s;
   logic                     tick_s;
   logic                     wrap_s;
   logic [NUM_LEDS-1:0]      raw_s;
   logic [NUM_LEDS-1:0]      ch_s;
   logic [31:0]              rdata_s;
   logic                     unused_s;

   assign idx_s    = PADDR[7:2];
   assign unused_s = ^{PADDR[31:8], PADDR[1:0], PWDATA};

   // Address decode: fixed registers plus one DUTY slot per implemented channel.
   always_comb begin
      is_duty_s = 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         is_duty_s = is_duty_s | (idx_s == IDX_DUTY0 + 6'(i));
      end
      case (idx_s)
         IDX_CTRL, IDX_PRESCALE, IDX_MODE, IDX_BLINK, IDX_STATUS: mapped_s = 1'b1;
         default:                                                 mapped_s = is_duty_s;
      endcase
   end

   assign wr_ok_s       = PSEL & PENABLE & PWRITE & mapped_s & (idx_s != IDX_STATUS);
   assign wr_prescale_s = wr_ok_s & (idx_s == IDX_PRESCALE);

   // Read mux; unmapped addresses and unused bits fall through as zero.
   always_comb begin
      rdata_s = 32'd0;
      case (idx_s)
         IDX_CTRL:     rdata_s[1:0]               = ctrl_q;
         IDX_PRESCALE: rdata_s[PRESCALE_BITS-1:0] = prescale_q;
         IDX_MODE:     rdata_s[2*NUM_LEDS-1:0]    = mode_q;
         IDX_BLINK:    rdata_s[15:0]              = blink_q;
         IDX_STATUS: begin
            rdata_s[PWM_BITS-1:0] = pwm_cnt_q;
            rdata_s[16]           = phase_q;
         end
         default: begin
            for (int i = 0; i < NUM_LEDS; i++) begin
               rdata_s[PWM_BITS-1:0] = rdata_s[PWM_BITS-1:0] |
                  ((idx_s == IDX_DUTY0 + 6'(i)) ? duty_q[i] : {PWM_BITS{1'b0}});
            end
         end
      endcase
   end

   assign PRDATA  = (PSEL && !PWRITE) ? rdata_s : 32'd0;
   assign PREADY  = 1'b1;
   assign PSLVERR = PSEL & PENABLE & (~mapped_s | (PWRITE & (idx_s == IDX_STATUS)));

   assign en_s   = ctrl_q[0];
   assign tick_s = en_s && (presc_cnt_q == prescale_q);
   assign wrap_s = tick_s && (pwm_cnt_q == {PWM_BITS{1'b1}});

   // Timebase next state: everything sits at zero while disabled.
   always_comb begin
      presc_cnt_d = {PRESCALE_BITS{1'b0}};
      pwm_cnt_d   = {PWM_BITS{1'b0}};
      blink_cnt_d = 16'd0;
      phase_d     = 1'b0;
      if (en_s) begin
         if (tick_s || wr_prescale_s) begin
            presc_cnt_d = {PRESCALE_BITS{1'b0}};
         end else begin
            presc_cnt_d = presc_cnt_q + PRESCALE_BITS'(1);
         end
         if (tick_s) begin
            pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
         end else begin
            pwm_cnt_d = pwm_cnt_q;
         end
         if (!wrap_s) begin
            blink_cnt_d = blink_cnt_q;
            phase_d     = phase_q;
         end else if (blink_cnt_q == blink_q) begin
            blink_cnt_d = 16'd0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 16'd1;
            phase_d     = phase_q;
         end
      end else begin
         phase_d = 1'b0;
      end
   end

   // Per-channel mode selection and output polarity.
   always_comb begin
      raw_s = {NUM_LEDS{1'b0}};
      ch_s  = {NUM_LEDS{1'b0}};
      led_d = {NUM_LEDS{1'b0}};
      for (int i = 0; i < NUM_LEDS; i++) begin
         raw_s[i] = (pwm_cnt_q < shadow_q[i]);
         case (mode_q[2*i +: 2])
            2'b00:   ch_s[i] = 1'b0;
            2'b01:   ch_s[i] = raw_s[i];
            2'b10:   ch_s[i] = raw_s[i] & phase_q;
            default: ch_s[i] = 1'b1;
         endcase
         led_d[i] = ctrl_q[1] ^ (en_s & ch_s[i]);
      end
   end

   // Software-visible register file.
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         ctrl_q     <= 2'b00;
         prescale_q <= {PRESCALE_BITS{1'b0}};
         mode_q     <= {(2*NUM_LEDS){1'b0}};
         blink_q    <= 16'd0;
         for (int i = 0; i < NUM_LEDS; i++) begin
            duty_q[i] <= {PWM_BITS{1'b0}};
         end
      end else begin
         if (wr_ok_s) begin
            case (idx_s)
               IDX_CTRL:     ctrl_q     <= PWDATA[1:0];
               IDX_PRESCALE: prescale_q <= PWDATA[PRESCALE_BITS-1:0];
               IDX_MODE:     mode_q     <= PWDATA[2*NUM_LEDS-1:0];
               IDX_BLINK:    blink_q    <= PWDATA[15:0];
               default:      ;
            endcase
         end
         for (int i = 0; i < NUM_LEDS; i++) begin
            if (wr_ok_s && (idx_s == IDX_DUTY0 + 6'(i))) begin
               duty_q[i] <= PWDATA[PWM_BITS-1:0];
            end
         end
      end
   end

   // Timebase, duty shadows (old DUTY wins on a coincident wrap) and LED register.
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         presc_cnt_q <= {PRESCALE_BITS{1'b0}};
         pwm_cnt_q   <= {PWM_BITS{1'b0}};
         blink_cnt_q <= 16'd0;
         phase_q     <= 1'b0;
         led_q       <= {NUM_LEDS{1'b0}};
         for (int i = 0; i < NUM_LEDS; i++) begin
            shadow_q[i] <= {PWM_BITS{1'b0}};
         end
      end else begin
         presc_cnt_q <= presc_cnt_d;
         pwm_cnt_q   <= pwm_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         led_q       <= led_d;
         for (int i = 0; i < NUM_LEDS; i++) begin
            if (!en_s || wrap_s) begin
               shadow_q[i] <= duty_q[i];
            end
         end
      end
   end

   assign LED = led_q;

endmodule
